pwm_multi_ch: RTL and testbench

Parametrised multi-channel successor to the single-channel button-controlled PWM. It drives CHANNELS independent PWM outputs from one shared carrier counter. Raw push-buttons are synchronised and debounced on chip. A select button chooses which channel the inc/dec buttons adjust. Duty changes are double-buffered so they apply only at period boundaries, which keeps the outputs glitch-free.

---
 rtl/pwm_multi_ch.sv | 205 ++++++++++++++++++++
 tb/tb_pwm_multi_ch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM generator with on-chip button conditioning.
//
// One shared carrier counter drives CHANNELS PWM outputs. Raw push-buttons
// are synchronised (2-FF) and debounced by a stable-level filter. btn_sel
// chooses the channel that btn_inc / btn_dec adjust. Duty changes go into a
// pending (shadow) register and are copied into the active register only on
// the edge into cnt==0, so outputs never glitch mid-period.
//
// Optional build macro: PWM_CENTER_ALIGNED_EN
//   undefined (default): edge-aligned carrier, cnt = 0..PERIOD-1, wraps to 0.
//   defined: centre-aligned carrier, cnt = 0..PERIOD-1 then PERIOD-2..1,
//            carrier length 2*(PERIOD-1); pulses centred on cnt==0.
//
// Ports:
//   clk          system clock
//   rst_a_p      asynchronous active-high reset
//   btn_inc      raw button, raise duty of the selected channel
//   btn_dec      raw button, lower duty of the selected channel
//   btn_sel      raw button, advance the selected channel
//   pwm_out      PWM outputs, bit i = channel i (decoded from registers)
//   ch_sel       currently selected channel
//   duty_sel     pending duty of the selected channel (decoded from registers)
//   period_start high during the cycle where cnt==0 (decoded from registers)

module pwm_multi_ch #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned PERIOD       = 100,
    parameter int unsigned DUTY_STEP    = 10,
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic                        clk,
    input  logic                        rst_a_p,
    input  logic                        btn_inc,
    input  logic                        btn_dec,
    input  logic                        btn_sel,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic [$clog2(CHANNELS)-1:0] ch_sel,
    output logic [CNT_W-1:0]            duty_sel,
    output logic                        period_start
);

    localparam int unsigned SEL_W = $clog2(CHANNELS);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned N_BTN = 3;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W:0]   DUTY_MAX = (CNT_W + 1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_W   = (CNT_W + 1)'(DUTY_STEP);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

    // Button index order inside the conditioning vectors.
    localparam int unsigned B_INC = 0;
    localparam int unsigned B_DEC = 1;
    localparam int unsigned B_SEL = 2;

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] deb;
    logic [N_BTN-1:0] deb_q;
    logic [N_BTN-1:0] btn_ev;
    logic [DB_W-1:0]  db_cnt [N_BTN];

    logic [CNT_W-1:0] pending [CHANNELS];
    logic [CNT_W-1:0] active  [CHANNELS];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [CNT_W-1:0] cur_pending;
    logic [CNT_W:0]   inc_sum;
    logic [CNT_W-1:0] inc_val;
    logic [CNT_W-1:0] dec_val;
    logic [SEL_W-1:0] ch_nxt;

    assign btn_raw = {btn_sel, btn_dec, btn_inc};

    // Synchroniser and stable-level filter for each button.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    // Level held for DEBOUNCE_CYC cycles: accept it.
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // One-cycle event on each debounced rising edge.
    assign btn_ev = deb & ~deb_q;

    // Saturating next-duty candidates for the selected channel.
    always_comb begin
        cur_pending = pending[ch_sel];
        inc_sum     = {1'b0, cur_pending} + STEP_W;
        inc_val     = (inc_sum > DUTY_MAX) ? CNT_W'(PERIOD) : inc_sum[CNT_W-1:0];
        dec_val     = ({1'b0, cur_pending} < STEP_W) ? '0
                                                     : CNT_W'({1'b0, cur_pending} - STEP_W);
        ch_nxt      = (ch_sel == SEL_LAST) ? '0 : ch_sel + SEL_W'(1);
    end

    // Event handling: inc/dec act on the current channel before sel advances it.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            ch_sel <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                pending[i] <= '0;
            end
        end else begin
            if (btn_ev[B_INC] && !btn_ev[B_DEC]) begin
                pending[ch_sel] <= inc_val;
            end else if (btn_ev[B_DEC] && !btn_ev[B_INC]) begin
                pending[ch_sel] <= dec_val;
            end
            if (btn_ev[B_SEL]) begin
                ch_sel <= ch_nxt;
            end
        end
    end

`ifdef PWM_CENTER_ALIGNED_EN
    logic count_up;
    logic count_up_nxt;

    // Up/down carrier: 0..PERIOD-1 up, PERIOD-2..1 down, then back to 0.
    always_comb begin
        cnt_nxt      = cnt;
        count_up_nxt = count_up;
        if (count_up) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt = cnt - CNT_W'(1);
                // With PERIOD==2 the down leg is empty and we land on 0 directly.
                if (cnt_nxt != '0) begin
                    count_up_nxt = 1'b0;
                end
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt_nxt == '0) begin
                count_up_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            count_up <= 1'b1;
        end else begin
            count_up <= count_up_nxt;
        end
    end
`else
    // Edge-aligned carrier: 0..PERIOD-1 then wrap.
    always_comb begin
        cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
`endif

    // Carrier register and double-buffer transfer on the edge into cnt==0.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            cnt <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                active[i] <= '0;
            end
        end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt == '0) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    active[i] <= pending[i];
                end
            end
        end
    end

    // Output decode from registers only.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_out[i] = (cnt < active[i]);
        end
        duty_sel     = pending[ch_sel];
        period_start = (cnt == '0);
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Scoreboard bench for pwm_multi_ch (default parameters).
// Stimulus pushes expected {ch_sel, duty_sel, cycle} changes and expected
// per-period high times; two monitors pop and compare as the DUT presents them.

module tb_pwm_multi_ch;

    localparam int CH    = 4;
    localparam int P     = 100;
    localparam int LAT   = 4 + 3;
`ifdef PWM_CENTER_ALIGNED_EN
    localparam int LEN   = 2 * (P - 1);
`else
    localparam int LEN   = P;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn_inc = 1'b0;
    logic          btn_dec = 1'b0;
    logic          btn_sel = 1'b0;
    logic [CH-1:0] pwm_out;
    logic [1:0]    ch_sel;
    logic [7:0]    duty_sel;
    logic          period_start;

    pwm_multi_ch dut (
        .clk          (clk),
        .rst_a_p      (rst),
        .btn_inc      (btn_inc),
        .btn_dec      (btn_dec),
        .btn_sel      (btn_sel),
        .pwm_out      (pwm_out),
        .ch_sel       (ch_sel),
        .duty_sel     (duty_sel),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int ch;
        int duty;
        int at;
    } chg_t;

    typedef struct {
        int armed;
        int h0;
        int h1;
        int h2;
        int h3;
    } per_t;

    chg_t chq[$];
    per_t pq[$];

    // Expected high time for a given active duty.
    function automatic int hi(input int a);
`ifdef PWM_CENTER_ALIGNED_EN
        if (a == 0) return 0;
        if (a >= P) return LEN;
        return 2 * a - 1;
`else
        return a;
`endif
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Monitor for ch_sel / duty_sel changes.
    int prev_ch   = 0;
    int prev_duty = 0;
    always @(negedge clk) begin
        chg_t e;
        if (rst) begin
            prev_ch   = int'(ch_sel);
            prev_duty = int'(duty_sel);
        end else if (int'(ch_sel) != prev_ch || int'(duty_sel) != prev_duty) begin
            n_cmp++;
            if (chq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got ch=%0d duty=%0d at cyc %0d, required no change",
                         ch_sel, duty_sel, cyc);
            end else begin
                e = chq.pop_front();
                if (int'(ch_sel) != e.ch || int'(duty_sel) != e.duty || cyc != e.at) begin
                    n_fail++;
                    $display("FAIL sel_duty_change: got ch=%0d duty=%0d at cyc %0d, required ch=%0d duty=%0d at cyc %0d",
                             ch_sel, duty_sel, cyc, e.ch, e.duty, e.at);
                end
            end
            prev_ch   = int'(ch_sel);
            prev_duty = int'(duty_sel);
        end
    end

    // Monitor for carrier periods and per-channel high time.
    int acc [CH];
    int start_cyc = 0;
    bit pvalid    = 1'b0;
    always @(negedge clk) begin
        per_t e;
        if (rst) begin
            pvalid = 1'b0;
        end else begin
            if (period_start) begin
                if (pvalid) begin
                    chk("period_length", cyc - start_cyc, LEN);
                    if (pq.size() != 0 && pq[0].armed <= start_cyc) begin
                        e = pq.pop_front();
                        chk("high_ch0", acc[0], e.h0);
                        chk("high_ch1", acc[1], e.h1);
                        chk("high_ch2", acc[2], e.h2);
                        chk("high_ch3", acc[3], e.h3);
                    end
                end
                for (int i = 0; i < CH; i++) acc[i] = 0;
                start_cyc = cyc;
                pvalid    = 1'b1;
            end
            for (int i = 0; i < CH; i++) acc[i] += int'(pwm_out[i]);
        end
    end

    // Drive one clean press: high 20 clk, low 10 clk. b = {sel, dec, inc}.
    task automatic press(input logic [2:0] b, input bit chg, input int ch, input int duty);
        chg_t e;
        @(negedge clk);
        if (chg) begin
            e.ch   = ch;
            e.duty = duty;
            e.at   = cyc + LAT;
            chq.push_back(e);
        end
        {btn_sel, btn_dec, btn_inc} = b;
        repeat (20) @(negedge clk);
        {btn_sel, btn_dec, btn_inc} = 3'b000;
        repeat (10) @(negedge clk);
    endtask

    task automatic bounce_inc();
        repeat (5) begin
            btn_inc = 1'b1;
            repeat (2) @(negedge clk);
            btn_inc = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic expect_period(input int a0, input int a1, input int a2, input int a3);
        per_t e;
        e.armed = cyc;
        e.h0 = hi(a0);
        e.h1 = hi(a1);
        e.h2 = hi(a2);
        e.h3 = hi(a3);
        pq.push_back(e);
    endtask

    task automatic drain(input int limit);
        for (int k = 0; k < limit && (chq.size() != 0 || pq.size() != 0); k++) @(negedge clk);
        n_cmp++;
        if (chq.size() != 0 || pq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d changes and %0d periods outstanding, required 0",
                     chq.size(), pq.size());
            chq.delete();
            pq.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_pwm_out", int'(pwm_out), 0);
        chk("rst_duty_sel", int'(duty_sel), 0);
        chk("rst_ch_sel", int'(ch_sel), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("first_period_start", int'(period_start), 1);
        @(negedge clk);
        chk("period_start_drop", int'(period_start), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("init_pwm_out", int'(pwm_out), 0);
        chk("init_duty_sel", int'(duty_sel), 0);
        chk("init_period_start", int'(period_start), 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // 1: load ch0 with 50, reset mid-period at cnt=37.
        for (int k = 1; k <= 5; k++) press(3'b001, 1'b1, 0, 10 * k);
        drain(200);
        @(negedge clk iff period_start);
        repeat (37) @(negedge clk);
        chk("pre_reset_pwm_out", int'(pwm_out), 1);
        do_reset();

        // 2: three presses inside one period; old duty holds until the wrap.
        @(negedge clk iff period_start);
        expect_period(0, 0, 0, 0);
        press(3'b001, 1'b1, 0, 10);
        press(3'b001, 1'b1, 0, 20);
        press(3'b001, 1'b1, 0, 30);
        expect_period(30, 0, 0, 0);
        drain(500);

        // 3: bounces ignored, saturation at PERIOD and at 0.
        bounce_inc();
        press(3'b010, 1'b1, 0, 20);
        press(3'b010, 1'b1, 0, 10);
        press(3'b010, 1'b1, 0, 0);
        for (int k = 1; k <= 11; k++) press(3'b001, k <= 10, 0, 10 * k);
        expect_period(100, 0, 0, 0);
        drain(600);
        for (int k = 1; k <= 11; k++) press(3'b010, k <= 10, 0, 100 - 10 * k);
        expect_period(0, 0, 0, 0);
        drain(600);

        // 4: channel selection wraps; inc lands only on ch2.
        press(3'b100, 1'b1, 1, 0);
        press(3'b100, 1'b1, 2, 0);
        press(3'b001, 1'b1, 2, 10);
        press(3'b100, 1'b1, 3, 0);
        press(3'b100, 1'b1, 0, 0);
        expect_period(0, 0, 10, 0);
        drain(600);

        // 5: inc+dec together ignored; inc+sel applies to old channel first.
        press(3'b100, 1'b1, 1, 0);
        press(3'b100, 1'b1, 2, 10);
        press(3'b011, 1'b0, 0, 0);
        press(3'b010, 1'b1, 2, 0);
        press(3'b100, 1'b1, 3, 0);
        press(3'b100, 1'b1, 0, 0);
        press(3'b100, 1'b1, 1, 0);
        press(3'b101, 1'b1, 2, 0);
        press(3'b100, 1'b1, 3, 0);
        press(3'b100, 1'b1, 0, 0);
        press(3'b100, 1'b1, 1, 10);
        expect_period(0, 10, 0, 0);
        drain(600);

`ifdef PWM_CENTER_ALIGNED_EN
        // 6: centre-aligned high time for active=10 on ch1.
        press(3'b100, 1'b1, 2, 0);
        press(3'b001, 1'b1, 2, 10);
        expect_period(0, 10, 10, 0);
        drain(600);
`endif

        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
